// File: rtl/tff_count_ctrl.sv
// ---------------------------------------------------------------------------
// tff_count_ctrl
//   Sequencer for a bank of W T flip-flops (the bank computes q <= q ^ t).
//   It reads the bank state back and drives per-bit toggle enables, so that
//   the bank acts as a loadable, prescaled up/down timer that runs from a
//   captured init value to a captured terminal value.
//
//   Optional feature macro: TFF_CTRL_RELOAD_EN
//     defined   : DONE goes back to LOAD with the captured values kept, which
//                 gives a periodic done pulse until stop or reset.
//     undefined : DONE goes to IDLE (one-shot).
//
// Parameters
//   W      width of the TFF bank (2..16)
//   PRESC  count advances once every PRESC clocks while running (1..255)
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     begin a sequence; sampled only in IDLE
//   stop_i      abort; wins over start and over terminal detect
//   up_i        direction (1 = up), captured on accepted start
//   init_val_i  start value, captured on accepted start
//   term_val_i  terminal value, captured on accepted start
//   q_i         current state of the TFF bank
//   t_o         toggle enables to the bank (combinational)
//   busy_o      high whenever the sequencer is not idle
//   done_o      one-cycle pulse while in DONE
// ---------------------------------------------------------------------------
module tff_count_ctrl #(
    parameter int W     = 4,
    parameter int PRESC = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         up_i,
    input  logic [W-1:0] init_val_i,
    input  logic [W-1:0] term_val_i,
    input  logic [W-1:0] q_i,
    output logic [W-1:0] t_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [7:0] PRESC_MAX = 8'(PRESC - 1);

    state_e       state_q, state_d;
    logic         up_q, up_d;
    logic [W-1:0] init_q, init_d;
    logic [W-1:0] term_q, term_d;
    logic [7:0]   presc_q, presc_d;

    logic         tick;
    logic [W-1:0] cnt_t;

    assign tick = (presc_q == PRESC_MAX);

    // Toggle pattern for a +/-1 step: bit i flips when every lower bit is 1
    // (counting up) or every lower bit is 0 (counting down).
    assign cnt_t[0] = 1'b1;
    for (genvar i = 1; i < W; i++) begin : g_cnt
        assign cnt_t[i] = up_q ? (&q_i[i-1:0]) : ~(|q_i[i-1:0]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            up_q    <= 1'b0;
            init_q  <= '0;
            term_q  <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            init_q  <= init_d;
            term_q  <= term_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        up_d    = up_q;
        init_d  = init_q;
        term_d  = term_q;
        presc_d = '0;
        t_o     = '0;
        busy_o  = (state_q != IDLE);
        done_o  = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    up_d    = up_i;
                    init_d  = init_val_i;
                    term_d  = term_val_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Flip exactly the bits that differ so the bank lands on init.
                t_o     = q_i ^ init_q;
                state_d = RUN;
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (q_i == term_q) begin
                    state_d = DONE;
                end else if (tick) begin
                    t_o = cnt_t;
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            DONE: begin
`ifdef TFF_CTRL_RELOAD_EN
                state_d = stop_i ? IDLE : LOAD;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
